// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave core.
// Holds the FSM state encoding, the default frame width and the
// packed mode-configuration payload latched while idle.
package spi_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Mode configuration captured while the bus is idle
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_cfg_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with edge detection for one asynchronous input.
// Ports:
//   clk, rst_n - system clock, async active-low reset
//   d          - asynchronous input
//   q          - synchronized level
//   rise_c     - one-cycle pulse when q goes 0->1
//   fall_c     - one-cycle pulse when q goes 1->0
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q      = sync_q;
  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave core, all four CPOL/CPHA modes, MSB- or LSB-first, oversampled
// on the system clock (i_sys_clk must run at least 4x SCK).
// Ports:
//   i_sys_clk, i_sys_rst           - system clock, async active-low reset
//   i_SCK, i_SS, i_MOSI, o_MISO    - SPI pins (asynchronous inputs)
//   o_MISO_oe                      - MISO drive enable while selected
//   i_cpol, i_cpha, i_lsb_first    - mode config, captured while idle
//   i_tx_data/i_tx_valid/o_tx_ready - TX holding-register handshake
//   o_rx_data/o_rx_valid/i_rx_ready - RX handshake
//   o_busy                         - frame in progress
//   o_underrun, o_overrun, i_clr_err - sticky errors and their clear
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_SCK,
  input  logic              i_SS,
  input  logic              i_MOSI,
  output logic              o_MISO,
  output logic              o_MISO_oe,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_busy,
  output logic              o_underrun,
  output logic              o_overrun,
  input  logic              i_clr_err
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  // Bit presented first on MISO for a given word and bit order
  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  state_e state_q, state_d;

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic [1:0] mosi_sync_q;
  logic       mosi_s;

  logic [1:0] flush_q;
  logic       armed_q;

  spi_cfg_t cfg_in, cfg_q, cfg;

  logic [DATA_W-1:0] hold_q;
  logic              hold_empty_q;
  logic [DATA_W-1:0] tx_sh_q;
  logic              tx_hold_q;
  logic              miso_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              under_pend_q;
  logic              underrun_q;
  logic              overrun_q;

  logic              start, stop, run;
  logic              sck_edge, lead, trail, sample, shift, last;
  logic              tx_acc, ld_empty, under_set, over_set;
  logic [DATA_W-1:0] ld_word, rx_nx, tx_nx;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk    (i_sys_clk),
    .rst_n  (i_sys_rst),
    .d      (i_SCK),
    .q      (sck_lvl),
    .rise_c (sck_rise),
    .fall_c (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (i_sys_clk),
    .rst_n  (i_sys_rst),
    .d      (i_SS),
    .q      (ss_lvl),
    .rise_c (ss_rise),
    .fall_c (ss_fall)
  );

  assign mosi_s = mosi_sync_q[1];
  assign cfg_in = '{cpol: i_cpol, cpha: i_cpha, lsb_first: i_lsb_first};

  // MOSI synchronizer, same latency as the SCK level so samples line up
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) mosi_sync_q <= 2'b00;
    else            mosi_sync_q <= {mosi_sync_q[0], i_MOSI};
  end

  // Arm only after SS has been seen high once the synchronizer has flushed,
  // so a select held low across reset release cannot start a frame.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      flush_q <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
      if (flush_q == 2'd3 && ss_lvl) armed_q <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state, edge classification and frame control
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    stop     = 1'b0;
    run      = 1'b0;
    cfg      = (state_q == ST_IDLE) ? cfg_in : cfg_q;
    sck_edge = sck_rise | sck_fall;
    lead     = sck_edge & (sck_lvl ^ cfg.cpol);
    trail    = sck_edge & ~(sck_lvl ^ cfg.cpol);

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && armed_q) begin
          state_d = ST_ACTIVE;
          start   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          stop    = 1'b1;
        end else begin
          run = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sample   = run & (cfg.cpha ? trail : lead);
    shift    = run & (cfg.cpha ? lead : trail);
    last     = sample && (bit_cnt_q == LAST_BIT);

    tx_acc   = i_tx_valid & hold_empty_q;
    ld_empty = hold_empty_q & ~i_tx_valid;
    if (!hold_empty_q)   ld_word = hold_q;
    else if (i_tx_valid) ld_word = i_tx_data;
    else                 ld_word = '1;

    rx_nx = cfg.lsb_first ? {mosi_s, rx_sh_q[DATA_W-1:1]}
                          : {rx_sh_q[DATA_W-2:0], mosi_s};
    tx_nx = cfg.lsb_first ? (tx_sh_q >> 1) : (tx_sh_q << 1);

    // A reloaded all-ones word only counts as underrun once the master clocks it
    under_set = (start & ld_empty) | (sample & (bit_cnt_q == '0) & under_pend_q);
    over_set  = last & rx_valid_q & ~i_rx_ready;
  end

  // Datapath: holding register, TX/RX shifters, handshakes, sticky errors
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      cfg_q        <= '0;
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      tx_sh_q      <= '0;
      tx_hold_q    <= 1'b0;
      miso_q       <= 1'b0;
      rx_sh_q      <= '0;
      bit_cnt_q    <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      under_pend_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) cfg_q <= cfg_in;

      // A word accepted in a frame-load cycle with an empty holder bypasses it
      if (frame_ld_c()) begin
        if (!hold_empty_q) hold_empty_q <= 1'b1;
      end else if (tx_acc) begin
        hold_q       <= i_tx_data;
        hold_empty_q <= 1'b0;
      end

      // tx_hold_q: next shift edge re-presents the first bit instead of shifting
      if (start) begin
        tx_sh_q   <= ld_word;
        miso_q    <= first_bit(ld_word, cfg.lsb_first);
        tx_hold_q <= cfg.cpha;
      end else if (stop) begin
        tx_sh_q   <= '0;
        miso_q    <= 1'b0;
        tx_hold_q <= 1'b0;
      end else if (last) begin
        tx_sh_q   <= ld_word;
        tx_hold_q <= 1'b1;
      end else if (shift) begin
        if (tx_hold_q) begin
          miso_q    <= first_bit(tx_sh_q, cfg.lsb_first);
          tx_hold_q <= 1'b0;
        end else begin
          tx_sh_q <= tx_nx;
          miso_q  <= first_bit(tx_nx, cfg.lsb_first);
        end
      end

      if (start || stop)                    under_pend_q <= 1'b0;
      else if (last)                        under_pend_q <= ld_empty;
      else if (sample && bit_cnt_q == '0)   under_pend_q <= 1'b0;

      if (start || stop) begin
        bit_cnt_q <= '0;
        rx_sh_q   <= '0;
      end else if (sample) begin
        rx_sh_q <= rx_nx;
        if (last) begin
          bit_cnt_q <= '0;
          rx_data_q <= rx_nx;
        end else begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
      end

      if (last)            rx_valid_q <= 1'b1;
      else if (i_rx_ready) rx_valid_q <= 1'b0;

      underrun_q <= under_set | (underrun_q & ~i_clr_err);
      overrun_q  <= over_set  | (overrun_q  & ~i_clr_err);
    end
  end

  function automatic logic frame_ld_c();
    return start | last;
  endfunction

  assign o_MISO     = miso_q;
  assign o_MISO_oe  = (state_q == ST_ACTIVE);
  assign o_busy     = (state_q == ST_ACTIVE);
  assign o_tx_ready = hold_empty_q;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_underrun = underrun_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed self-checking bench for spi_slave_core: acts as the SPI master
// and the host, checking received data, MISO bit streams and status flags.
module tb_spi_slave_core;

  localparam int HALF = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic       cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy, underrun, overrun;
  logic       clr_err = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int valid_rises = 0;
  logic valid_d = 1'b0;

  spi_slave_core #(.DATA_W(8)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst_n),
    .i_SCK       (sck),
    .i_SS        (ss),
    .i_MOSI      (mosi),
    .o_MISO      (miso),
    .o_MISO_oe   (miso_oe),
    .i_cpol      (cpol),
    .i_cpha      (cpha),
    .i_lsb_first (lsb),
    .i_tx_data   (tx_data),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (tx_ready),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .i_rx_ready  (rx_ready),
    .o_busy      (busy),
    .o_underrun  (underrun),
    .o_overrun   (overrun),
    .i_clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && !valid_d) valid_rises++;
    valid_d = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_rx_ready();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Master side: clocks nbits, returns MISO bits placed at their word position
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int b;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = lsb ? i : 7 - i;
      if (!cpha) mosi = mo[b];
      #(HALF) sck = ~cpol;
      if (!cpha) mi[b] = miso;
      else       mosi = mo[b];
      #(HALF) sck = cpol;
      if (cpha) mi[b] = miso;
    end
  endtask

  initial begin
    logic [7:0] r1, r2;

    // Reset state
    cycles(3);
    chk("rst_tx_ready", 32'(tx_ready), 32'h1);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_flags", {30'd0, underrun, overrun}, 32'h0);
    rst_n = 1'b1;
    cycles(10);

    // Mode 0, MSB first: TX 0x3C, master sends 0xA5
    push_tx(8'h3C);
    chk("m0_tx_ready_full", 32'(tx_ready), 32'h0);
    ss = 1'b0;
    cycles(8);
    chk("m0_busy", 32'(busy), 32'h1);
    chk("m0_oe", 32'(miso_oe), 32'h1);
    xfer(8'hA5, 8, r1);
    cycles(8);
    chk("m0_miso_bits", 32'(r1), 32'h3C);
    chk("m0_rx_data", 32'(rx_data), 32'hA5);
    chk("m0_rx_valid", 32'(rx_valid), 32'h1);
    chk("m0_valid_once", 32'(valid_rises), 32'h1);
    ss = 1'b1;
    cycles(8);
    chk("m0_idle_busy", 32'(busy), 32'h0);
    chk("m0_idle_oe", 32'(miso_oe), 32'h0);
    chk("m0_idle_miso", 32'(miso), 32'h0);
    pulse_rx_ready();
    chk("m0_rx_ack", 32'(rx_valid), 32'h0);

    // Mode 3, LSB first: TX 0x81, master sends 0x5A
    cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; sck = 1'b1;
    cycles(8);
    push_tx(8'h81);
    ss = 1'b0;
    cycles(8);
    xfer(8'h5A, 8, r1);
    cycles(8);
    chk("m3_miso_bits", 32'(r1), 32'h81);
    chk("m3_rx_data", 32'(rx_data), 32'h5A);
    chk("m3_rx_valid", 32'(rx_valid), 32'h1);
    ss = 1'b1;
    cycles(8);
    pulse_rx_ready();

    // Back-to-back frames in mode 0 with RX never acknowledged
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sck = 1'b0;
    cycles(8);
    push_tx(8'h11);
    ss = 1'b0;
    cycles(8);
    push_tx(8'h22);
    xfer(8'h96, 8, r1);
    xfer(8'h3D, 8, r2);
    cycles(8);
    chk("b2b_miso_1", 32'(r1), 32'h11);
    chk("b2b_miso_2", 32'(r2), 32'h22);
    chk("b2b_rx_data", 32'(rx_data), 32'h3D);
    chk("b2b_overrun", 32'(overrun), 32'h1);
    ss = 1'b1;
    cycles(8);
    pulse_rx_ready();
    pulse_clr();
    chk("b2b_ovr_clr", 32'(overrun), 32'h0);

    // Empty holding register: all-ones, underrun, then clear
    chk("ur_tx_ready", 32'(tx_ready), 32'h1);
    ss = 1'b0;
    cycles(8);
    xfer(8'h00, 8, r1);
    cycles(8);
    chk("ur_miso_ff", 32'(r1), 32'hFF);
    chk("ur_flag", 32'(underrun), 32'h1);
    chk("ur_rx_data", 32'(rx_data), 32'h00);
    ss = 1'b1;
    cycles(8);
    pulse_clr();
    chk("ur_clr", 32'(underrun), 32'h0);
    pulse_rx_ready();

    // SS rises after 5 bits; a word queued mid-frame must survive
    push_tx(8'hC3);
    ss = 1'b0;
    cycles(8);
    push_tx(8'h5B);
    xfer(8'hFF, 5, r1);
    ss = 1'b1;
    cycles(8);
    chk("ab_rx_valid", 32'(rx_valid), 32'h0);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_hold_kept", 32'(tx_ready), 32'h0);
    ss = 1'b0;
    cycles(8);
    xfer(8'h77, 8, r1);
    cycles(8);
    chk("ab_next_miso", 32'(r1), 32'h5B);
    chk("ab_next_rx", 32'(rx_data), 32'h77);
    chk("ab_next_valid", 32'(rx_valid), 32'h1);
    ss = 1'b1;
    cycles(8);

    // Reset asserted mid-frame at bit 3
    push_tx(8'hE7);
    ss = 1'b0;
    cycles(8);
    push_tx(8'h99);
    xfer(8'h12, 3, r1);
    chk("mr_pre_busy", 32'(busy), 32'h1);
    chk("mr_pre_tx_ready", 32'(tx_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_tx_ready", 32'(tx_ready), 32'h1);
    chk("mr_rx_valid", 32'(rx_valid), 32'h0);
    chk("mr_rx_data", 32'(rx_data), 32'h00);
    chk("mr_miso", 32'(miso), 32'h0);
    chk("mr_oe", 32'(miso_oe), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_flags", {30'd0, underrun, overrun}, 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    chk("mr_no_restart", 32'(busy), 32'h0);
    ss = 1'b1;
    cycles(8);
    push_tx(8'h6E);
    ss = 1'b0;
    cycles(8);
    xfer(8'hC9, 8, r1);
    cycles(8);
    chk("mr_next_miso", 32'(r1), 32'h6E);
    chk("mr_next_rx", 32'(rx_data), 32'hC9);
    chk("mr_next_valid", 32'(rx_valid), 32'h1);
    ss = 1'b1;
    cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 The block SHALL have one parameter, DATA_W, default 8, setting the frame width in bits.
REQ-002 i_sys_clk  input  1  system clock; the only clock; all flops rise-edge.
REQ-003 i_sys_rst  input  1  reset, asynchronous, active-low.
REQ-004 i_SCK  input  1  serial clock from master, asynchronous to i_sys_clk.
REQ-005 i_SS  input  1  slave select, active-low, asynchronous.
REQ-006 i_MOSI  input  1  serial data from master.
REQ-007 o_MISO  output  1  serial data to master; o_MISO_oe  output  1  MISO drive enable, high only while selected.
REQ-008 i_cpol, i_cpha, i_lsb_first  input  1 each  mode config; sampled only in IDLE.
REQ-009 i_tx_data  input  DATA_W; i_tx_valid  input  1; o_tx_ready  output  1  TX holding-register handshake.
REQ-010 o_rx_data  output  DATA_W; o_rx_valid  output  1; i_rx_ready  input  1  RX handshake.
REQ-011 o_busy  output  1  frame in progress; o_underrun, o_overrun  output  1  sticky errors; i_clr_err  input  1  clears both.

Function
REQ-012 i_SCK, i_SS and i_MOSI SHALL each pass a 2-flop synchronizer; i_sys_clk SHALL be at least 4x SCK frequency.
REQ-013 Leading edge = SCK leaving the i_cpol idle level; trailing edge = its return; sample edge = leading if i_cpha=0, else trailing; shift edge = the other.
REQ-014 FSM states: IDLE, ACTIVE; IDLE->ACTIVE on synchronized SS falling; ACTIVE->IDLE on synchronized SS rising, from any bit count.
REQ-015 On IDLE->ACTIVE, the holding register SHALL be copied to the TX shift register and the first bit (MSB, or LSB if i_lsb_first) SHALL be driven on o_MISO the same cycle.
REQ-016 If the holding register is empty at frame load, all-ones SHALL be transmitted and o_underrun set.
REQ-017 Each sample edge SHALL shift synchronized MOSI into the RX shift register; each shift edge SHALL advance o_MISO by one bit, except the shift edge immediately following frame load when i_cpha=1.
REQ-018 On the DATA_W-th sample edge: o_rx_data loaded, o_rx_valid set, bit counter wraps to 0, and the holding register reloads the TX shift register for back-to-back frames without SS deassertion.
REQ-019 o_rx_valid SHALL stay high until i_rx_ready is sampled high; a frame completing while o_rx_valid is high SHALL overwrite o_rx_data and set o_overrun.
REQ-020 o_tx_ready SHALL be high when the holding register is empty; i_tx_valid&&o_tx_ready loads it; a load and a frame-load in the same cycle SHALL pass the new word straight to the shift register.
REQ-021 SS rising mid-frame SHALL discard partial RX bits, leave o_rx_valid unchanged, and retain any unsent holding-register word.
REQ-022 o_MISO_oe and o_busy SHALL equal (state==ACTIVE); o_MISO SHALL be 0 when o_MISO_oe is low.
REQ-023 i_clr_err SHALL clear both sticky flags; a set event in the same cycle SHALL take priority.

Reset
REQ-024 Asserted i_sys_rst SHALL immediately force: state IDLE, counters 0, shift and holding registers 0, holding empty, o_tx_ready=1, o_rx_valid=0, o_rx_data=0, o_MISO=0, o_MISO_oe=0, o_busy=0, o_underrun=0, o_overrun=0, synchronizers to SS=1 and SCK=0.
REQ-025 Reset mid-frame SHALL abort it; after release, a frame SHALL start only on a fresh SS falling edge.

Structure
REQ-026 Package spi_pkg SHALL hold the FSM state enum and the DATA_W default constant.
REQ-027 One sub-module, spi_sync_edge (2-flop synchronizer plus rise/fall pulse detect), SHALL be instantiated for SCK and SS.

Verification
REQ-028 Mode 0, MSB-first, TX 0x3C, master sends 0xA5 -> o_rx_data=0xA5, one o_rx_valid, MISO bits 0,0,1,1,1,1,0,0.
REQ-029 Mode 3, LSB-first, TX 0x81, master sends 0x5A -> o_rx_data=0x5A, MISO bits 1,0,0,0,0,0,0,1.
REQ-030 Two back-to-back frames, TX 0x11 then 0x22, SS held low, i_rx_ready held 0 -> second o_rx_data=the second master byte, o_overrun=1.
REQ-031 Frame with holding register empty -> MISO 0xFF, o_underrun=1; i_clr_err pulse -> o_underrun=0.
REQ-032 SS rises after 5 bits -> o_rx_valid stays 0, state IDLE; the next full frame receives correctly.
REQ-033 Reset asserted mid-frame at bit 3 -> all outputs at REQ-024 values in the same cycle; the next frame after release is correct.
